// File: rtl/axi4_lite_read_slave.sv
// axi4_lite_read_slave: AXI4-lite read responder forwarding one AR transaction at a time to a backend port
//
// Optional feature: define AXI_READ_ALIGN_CHECK_EN to answer misaligned (addr[2:0]!=0)
// reads with SLVERR directly, without touching the backend.
//
// Ports:
//   clk_i, rst_ni               clock (rising edge), asynchronous active-low reset
//   ar_addr_i/valid_i/ready_o   AXI read address channel
//   ar_port_i                   protection bits, accepted and ignored
//   r_data_o/resp_o/valid_o     AXI read data channel (resp 00 OKAY, 10 SLVERR)
//   r_ready_i
//   read_req_o, read_addr_o     backend request (level, held until ack) and address
//   read_ack_i, read_data_i     backend single-cycle data-valid pulse and data
module axi4_lite_read_slave #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] ar_addr_i,
    input  logic              ar_valid_i,
    output logic              ar_ready_o,
    input  logic [2:0]        ar_port_i,
    output logic [DATA_W-1:0] r_data_o,
    output logic [1:0]        r_resp_o,
    output logic              r_valid_o,
    input  logic              r_ready_i,
    output logic              read_req_o,
    output logic [ADDR_W-1:0] read_addr_o,
    input  logic              read_ack_i,
    input  logic [DATA_W-1:0] read_data_i
);
    typedef enum logic [1:0] {IDLE, FETCH, RESP} state_e;

    state_e            state_q, state_d;
    logic              ar_ready_q, ar_ready_d;
    logic              r_valid_q, r_valid_d;
    logic [DATA_W-1:0] r_data_q, r_data_d;
    logic [1:0]        r_resp_q, r_resp_d;
    logic              read_req_q, read_req_d;
    logic [ADDR_W-1:0] read_addr_q, read_addr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              unused_port;

    assign unused_port = ^ar_port_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ar_ready_q  <= 1'b1;
            r_valid_q   <= 1'b0;
            r_data_q    <= '0;
            r_resp_q    <= 2'b00;
            read_req_q  <= 1'b0;
            read_addr_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ar_ready_q  <= ar_ready_d;
            r_valid_q   <= r_valid_d;
            r_data_q    <= r_data_d;
            r_resp_q    <= r_resp_d;
            read_req_q  <= read_req_d;
            read_addr_q <= read_addr_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ar_ready_d  = ar_ready_q;
        r_valid_d   = r_valid_q;
        r_data_d    = r_data_q;
        r_resp_d    = r_resp_q;
        read_req_d  = read_req_q;
        read_addr_d = read_addr_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (ar_valid_i && ar_ready_q) begin
                    read_addr_d = ar_addr_i;
                    ar_ready_d  = 1'b0;
                    cnt_d       = '0;
`ifdef AXI_READ_ALIGN_CHECK_EN
                    if (ar_addr_i[2:0] != 3'b000) begin
                        r_data_d  = '0;
                        r_resp_d  = 2'b10;
                        r_valid_d = 1'b1;
                        state_d   = RESP;
                    end else begin
                        read_req_d = 1'b1;
                        state_d    = FETCH;
                    end
`else
                    read_req_d = 1'b1;
                    state_d    = FETCH;
`endif
                end
            end
            FETCH: begin
                // ack has priority over a timeout expiring in the same cycle
                if (read_ack_i) begin
                    r_data_d   = read_data_i;
                    r_resp_d   = 2'b00;
                    read_req_d = 1'b0;
                    r_valid_d  = 1'b1;
                    state_d    = RESP;
                end else if (cnt_q == 8'(TIMEOUT)) begin
                    r_data_d   = '0;
                    r_resp_d   = 2'b10;
                    read_req_d = 1'b0;
                    r_valid_d  = 1'b1;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (r_ready_i) begin
                    r_valid_d  = 1'b0;
                    ar_ready_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ar_ready_o  = ar_ready_q;
    assign r_valid_o   = r_valid_q;
    assign r_data_o    = r_data_q;
    assign r_resp_o    = r_resp_q;
    assign read_req_o  = read_req_q;
    assign read_addr_o = read_addr_q;
endmodule

// File: tb/tb_axi4_lite_read_slave.sv
// tb_axi4_lite_read_slave: directed self-checking bench for axi4_lite_read_slave
module tb_axi4_lite_read_slave;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] ar_addr;
    logic        ar_valid;
    logic        ar_ready;
    logic [2:0]  ar_port;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_valid;
    logic        r_ready;
    logic        read_req;
    logic [63:0] read_addr;
    logic        read_ack;
    logic [63:0] read_data;
    int          tests = 0;
    int          fails = 0;

    axi4_lite_read_slave dut (
        .clk_i(clk), .rst_ni(rst_n),
        .ar_addr_i(ar_addr), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_port_i(ar_port),
        .r_data_o(r_data), .r_resp_o(r_resp), .r_valid_o(r_valid), .r_ready_i(r_ready),
        .read_req_o(read_req), .read_addr_o(read_addr),
        .read_ack_i(read_ack), .read_data_i(read_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [63:0] a);
        ar_addr  = a;
        ar_valid = 1'b1;
        tick();
        ar_valid = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        rst_n = 1'b0; ar_addr = '0; ar_valid = 1'b0; ar_port = 3'b000;
        r_ready = 1'b0; read_ack = 1'b0; read_data = '0;
        tick(); tick();
        check("rst_ar_ready", ar_ready, 1);
        check("rst_r_valid", r_valid, 0);
        check("rst_r_data", r_data, 0);
        check("rst_r_resp", r_resp, 0);
        check("rst_read_req", read_req, 0);
        check("rst_read_addr", read_addr, 0);
        rst_n = 1'b1;
        tick();

        read_ack = 1'b1; read_data = 64'h5555;
        tick();
        read_ack = 1'b0;
        check("idle_ack_ignored", r_valid, 0);

        // basic read, ack in first FETCH cycle
        r_ready = 1'b1; ar_port = 3'b101;
        accept(64'h8000_0010);
        check("t2_read_req", read_req, 1);
        check("t2_read_addr", read_addr, 64'h8000_0010);
        check("t2_ar_ready_low", ar_ready, 0);
        check("t2_r_valid_early", r_valid, 0);
        read_ack = 1'b1; read_data = 64'hDEAD_BEEF_0123_4567;
        tick();
        read_ack = 1'b0;
        check("t2_r_valid", r_valid, 1);
        check("t2_r_data", r_data, 64'hDEAD_BEEF_0123_4567);
        check("t2_r_resp", r_resp, 0);
        check("t2_req_drop", read_req, 0);
        tick();
        check("t2_r_done", r_valid, 0);
        check("t2_ar_ready", ar_ready, 1);

        // reset mid-FETCH
        accept(64'h40);
        check("t1_in_fetch", read_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t1_req_fall", read_req, 0);
        check("t1_r_valid", r_valid, 0);
        check("t1_ar_ready", ar_ready, 1);
        rst_n = 1'b1;
        tick();

        // R back-pressure with a second AR waiting
        r_ready = 1'b0;
        accept(64'h1000);
        read_ack = 1'b1; read_data = 64'h1111_2222_3333_4444;
        tick();
        read_ack = 1'b0;
        ar_addr = 64'h2000; ar_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", r_valid, 1);
            check("t3_hold_data", r_data, 64'h1111_2222_3333_4444);
            check("t3_hold_resp", r_resp, 0);
            check("t3_ar_blocked", ar_ready, 0);
            tick();
        end
        check("t3_no_second_req", read_req, 0);
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        check("t3_r_done", r_valid, 0);
        check("t3_ar_ready", ar_ready, 1);
        tick();
        ar_valid = 1'b0;
        check("t3_second_req", read_req, 1);
        check("t3_second_addr", read_addr, 64'h2000);
        read_ack = 1'b1; read_data = 64'h77;
        tick();
        read_ack = 1'b0;
        check("t3_second_data", r_data, 64'h77);
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;

        // timeout: 256 FETCH cycles (counter 0..255) with no ack
        accept(64'h3000);
        hi = 0;
        for (int i = 0; i < 300; i++) begin
            if (r_valid) break;
            if (read_req) hi++;
            tick();
        end
        check("t4_fetch_cycles", 64'(hi), 256);
        check("t4_r_valid", r_valid, 1);
        check("t4_r_resp", r_resp, 2'b10);
        check("t4_r_data", r_data, 0);
        check("t4_req_drop", read_req, 0);
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        check("t4_r_done", r_valid, 0);

        // ack on the same cycle the counter reaches TIMEOUT
        accept(64'h3008);
        for (int i = 0; i < 255; i++) tick();
        check("t5_still_fetch", read_req, 1);
        check("t5_no_valid_yet", r_valid, 0);
        read_ack = 1'b1; read_data = 64'hCAFE_F00D_0000_0001;
        tick();
        read_ack = 1'b0;
        check("t5_r_valid", r_valid, 1);
        check("t5_r_resp", r_resp, 0);
        check("t5_r_data", r_data, 64'hCAFE_F00D_0000_0001);
        r_ready = 1'b1;
        tick();

        // misaligned address
        accept(64'h8000_0004);
`ifdef AXI_READ_ALIGN_CHECK_EN
        check("t6_no_req", read_req, 0);
        check("t6_r_valid", r_valid, 1);
        check("t6_r_resp", r_resp, 2'b10);
        check("t6_r_data", r_data, 0);
`else
        check("t6_req", read_req, 1);
        check("t6_read_addr", read_addr, 64'h8000_0004);
        read_ack = 1'b1; read_data = 64'hABCD;
        tick();
        read_ack = 1'b0;
        check("t6_r_resp", r_resp, 0);
        check("t6_r_data", r_data, 64'hABCD);
`endif
        tick();
        check("t6_r_done", r_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
